dmem_responder: RTL and testbench

- Data-memory responder for the RV32I pipeline MEM stage.
- Accepts load/store requests, qualified by the decoded MemRead/MemWrite strobes and the instruction funct3, against an internal word-organised RAM with a programmable access latency.
- Returns sign/zero-extended load data with a one-cycle Done pulse, and holds the pipeline via Stall while an access is in flight.
- Flags misaligned or illegal accesses without touching memory.

---
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// RV32I MEM-stage data memory responder: word-organised RAM with programmable
// access latency, byte/half/word loads and stores, and misalignment/illegal flagging.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic is_legal(input logic st, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b100:  return !st;
      3'b001:  return !a[0];
      3'b101:  return !st && !a[0];
      3'b010:  return a == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  logic [31:0]       mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              st_q;
  logic [31:0]       rdata_q;
  logic              done_q, err_q, err_d;
  logic              commit;
  logic              unused_addr_hi;

  logic req, both, legal, accept;
  assign both   = MemRead & MemWrite;
  assign req    = MemRead ^ MemWrite;
  assign legal  = is_legal(MemWrite, Funct3, Addr[1:0]);
  assign accept = (state_q == IDLE) && req && legal;
  assign unused_addr_hi = ^Addr[31:ADDR_W];

  // With zero latency the commit happens in the acceptance cycle, straight from the inputs.
  logic              from_in;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wd;
  logic [2:0]        acc_f3;
  logic              acc_st;
  logic [ADDR_W-3:0] acc_idx;
  assign from_in  = (state_q == IDLE);
  assign acc_addr = from_in ? Addr[ADDR_W-1:0] : addr_q;
  assign acc_wd   = from_in ? WrData : wdata_q;
  assign acc_f3   = from_in ? Funct3 : f3_q;
  assign acc_st   = from_in ? MemWrite : st_q;
  assign acc_idx  = acc_addr[ADDR_W-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    Stall   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          Stall = 1'b1;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
          end
        end else if (both || req) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [3:0]  be;
  logic [31:0] wlanes;
  always_comb begin
    be     = 4'b0000;
    wlanes = acc_wd;
    case (acc_f3)
      3'b000: begin
        be     = 4'b0001 << acc_addr[1:0];
        wlanes = {4{acc_wd[7:0]}};
      end
      3'b001: begin
        be     = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{acc_wd[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == RESP);
      err_q   <= err_d;
      if (commit && !acc_st)
        rdata_q <= load_ext(mem_q[acc_idx], acc_f3, acc_addr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= Addr[ADDR_W-1:0];
      wdata_q <= WrData;
      f3_q    <= Funct3;
      st_q    <= MemWrite;
    end
  end

  // RAM is never cleared; reset only blocks a store that would commit at this edge.
  always_ff @(posedge clk) begin
    if (commit && acc_st && !reset) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[acc_idx][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end

  assign RdData = rdata_q;
  assign Done   = done_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0,
// selected by sel; the idle instance sees no requests.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic        sel;

  logic        rd2, wr2, rd0, wr0;
  logic [31:0] RdData2, RdData0;
  logic        Stall2, Done2, Err2, Stall0, Done0, Err0;
  logic [31:0] obs_rd;
  logic        obs_stall, obs_done, obs_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd2 = sel & MemRead;
  assign wr2 = sel & MemWrite;
  assign rd0 = ~sel & MemRead;
  assign wr0 = ~sel & MemWrite;

  assign obs_rd    = sel ? RdData2 : RdData0;
  assign obs_stall = sel ? Stall2 : Stall0;
  assign obs_done  = sel ? Done2 : Done0;
  assign obs_err   = sel ? Err2 : Err0;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .MemRead(rd2), .MemWrite(wr2), .Funct3(Funct3),
    .Addr(Addr), .WrData(WrData), .RdData(RdData2), .Stall(Stall2), .Done(Done2), .Err(Err2)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .Funct3(Funct3),
    .Addr(Addr), .WrData(WrData), .RdData(RdData0), .Stall(Stall0), .Done(Done0), .Err(Err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Funct3   = 3'b010;
    Addr     = 32'd0;
    WrData   = 32'd0;
  endtask

  // Legal access: Stall in cycles 0..lat, Done exactly in cycle lat+1.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    #1;
    chk({tag, ".stall0"}, {31'd0, obs_stall}, 32'd1);
    chk({tag, ".done0"}, {31'd0, obs_done}, 32'd0);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Request changes after acceptance must not affect the access.
        Addr = 32'h0000_0004; WrData = 32'h7777_7777; Funct3 = 3'b000;
        #1;
      end
      chk({tag, ".stall"}, {31'd0, obs_stall}, {31'd0, c <= lat});
      chk({tag, ".done"}, {31'd0, obs_done}, {31'd0, c == lat + 1});
      chk({tag, ".err"}, {31'd0, obs_err}, 32'd0);
    end
    chk({tag, ".rdata"}, obs_rd, exp_rd);
    idle_inputs();
  endtask

  // Illegal request: Err in cycle 1, never Stall or Done.
  task automatic bad_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    #1;
    chk({tag, ".stall0"}, {31'd0, obs_stall}, 32'd0);
    @(negedge clk);
    chk({tag, ".err1"}, {31'd0, obs_err}, 32'd1);
    chk({tag, ".done1"}, {31'd0, obs_done}, 32'd0);
    chk({tag, ".stall1"}, {31'd0, obs_stall}, 32'd0);
    idle_inputs();
    @(negedge clk);
    chk({tag, ".err2"}, {31'd0, obs_err}, 32'd0);
    chk({tag, ".done2"}, {31'd0, obs_done}, 32'd0);
    chk({tag, ".rdata"}, obs_rd, exp_rd);
  endtask

  initial begin
    idle_inputs();
    sel   = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.rdata2", RdData2, 32'd0);
    chk("rst.rdata0", RdData0, 32'd0);
    chk("rst.flags2", {29'd0, Stall2, Done2, Err2}, 32'd0);
    chk("rst.flags0", {29'd0, Stall0, Done0, Err0}, 32'd0);
    reset = 1'b0;

    // LATENCY=2
    access("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0);
    access("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF);
    access("lb13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFFFFDE);
    access("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h000000DE);
    access("lh10", 1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 2, 32'hFFFFBEEF);
    access("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 2, 32'h0000DEAD);
    access("sb11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055, 2, 32'h0000DEAD);
    access("lw10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD55EF);
    access("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'h00001234, 2, 32'hDEAD55EF);
    access("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h123455EF);

    bad_access("e_lw12", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h123455EF);
    bad_access("e_sh11", 1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h123455EF);
    bad_access("e_f3_011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h123455EF);
    bad_access("e_both", 1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 32'h123455EF);
    bad_access("e_sbu", 1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h123455EF);
    access("lw10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'h123455EF);

    // Reset in WAIT aborts an uncommitted store.
    access("sw30z", 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 2, 32'h123455EF);
    @(negedge clk);
    MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h30; WrData = 32'hA5A5A5A5;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw.stall", {31'd0, Stall2}, 32'd0);
    chk("rstw.done", {31'd0, Done2}, 32'd0);
    @(negedge clk);
    chk("rstw.done2", {31'd0, Done2}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rstw.done4", {31'd0, Done2}, 32'd0);
    access("lw30", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 2, 32'h00000000);

    // LATENCY=0 with address aliasing
    sel = 1'b0;
    access("z_sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 32'h0);
    access("z_lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, 32'hCAFEF00D);
    access("z_lw420", 1'b1, 1'b0, 3'b010, 32'h420, 32'h0, 0, 32'hCAFEF00D);
    access("z_sw420", 1'b0, 1'b1, 3'b010, 32'h420, 32'h01020304, 0, 32'hCAFEF00D);
    access("z_lw20b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h01020304);
    access("z_lb23", 1'b1, 1'b0, 3'b000, 32'h23, 32'h0, 0, 32'h00000001);
    bad_access("z_e_lh21", 1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 32'h00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
